// File: rtl/gtc_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gtc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } gtc_state_e;

   localparam int unsigned NUM_VECTORS = 4;
   localparam int unsigned ERR_W       = 3;

endpackage

// File: rtl/gtc_settle_timer.sv
// Settle timer: counts enabled clocks and flags the last settle clock of a vector.
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired = enable && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = expired ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks the four {a,b} vectors, samples gate_y after settling and reports errors.
// Optional GTC_FAIL_MASK_EN adds a per-vector fail_mask output.
module gate_truth_table_checker
   import gtc_pkg::*;
#(
   parameter logic [3:0]  EXPECT        = 4'b0001,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             gate_y,
   output logic             gate_a,
   output logic             gate_b,
   output logic [1:0]       vec_idx,
   output logic             busy,
   output logic             done,
   output logic             pass,
`ifdef GTC_FAIL_MASK_EN
   output logic [3:0]       fail_mask,
`endif
   output logic [ERR_W-1:0] err_count
);

   localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

   gtc_state_e       state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [3:0]       mask_q, mask_d;
   logic             timer_clear, timer_en, expired;
   logic             mismatch;

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (expired)
   );

   assign mismatch = (gate_y != EXPECT[vec_q]);

   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      err_d       = err_q;
      pass_d      = pass_q;
      mask_d      = mask_q;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = SETTLE;
               vec_d       = '0;
               err_d       = '0;
               pass_d      = 1'b0;
               mask_d      = '0;
               timer_clear = 1'b1;
            end
         end
         SETTLE: begin
            timer_en = 1'b1;
            if (expired)
               state_d = SAMPLE;
         end
         SAMPLE: begin
            timer_clear   = 1'b1;
            mask_d[vec_q] = mismatch;
            if (mismatch)
               err_d = err_q + ERR_W'(1);
            // pass must reflect the compare made in this same cycle
            if (vec_q == LAST_VEC) begin
               state_d = DONE;
               pass_d  = (err_d == '0);
            end else begin
               vec_d   = vec_q + 2'd1;
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
      end
   end

   assign gate_a    = vec_q[1];
   assign gate_b    = vec_q[0];
   assign vec_idx   = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
`ifdef GTC_FAIL_MASK_EN
   assign fail_mask = mask_q;
`else
   logic unused_mask;
   assign unused_mask = ^mask_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: NOR checker (settle 2) with selectable gate_y, NAND checker (settle 1).
module tb_gate_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start2;
   logic [1:0] ymode;

   logic       a1, b1, y1, busy1, done1, pass1;
   logic [1:0] vec1;
   logic [2:0] err1;
   logic       a2, b2, y2, busy2, done2, pass2;
   logic [1:0] vec2;
   logic [2:0] err2;
`ifdef GTC_FAIL_MASK_EN
   logic [3:0] mask1, mask2;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   // ymode: 0 = real NOR, 1 = tied 0, 2 = tied 1
   assign y1 = (ymode == 2'd0) ? ~(a1 | b1) : (ymode == 2'd1) ? 1'b0 : 1'b1;
   assign y2 = ~(a2 & b2);

   gate_truth_table_checker #(
      .EXPECT        (4'b0001),
      .SETTLE_CYCLES (2),
      .CNT_W         (4)
   ) u_nor (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .gate_y    (y1),
      .gate_a    (a1),
      .gate_b    (b1),
      .vec_idx   (vec1),
      .busy      (busy1),
      .done      (done1),
      .pass      (pass1),
`ifdef GTC_FAIL_MASK_EN
      .fail_mask (mask1),
`endif
      .err_count (err1)
   );

   gate_truth_table_checker #(
      .EXPECT        (4'b0111),
      .SETTLE_CYCLES (1),
      .CNT_W         (4)
   ) u_nand (
      .clk       (clk),
      .rst       (rst),
      .start     (start2),
      .gate_y    (y2),
      .gate_a    (a2),
      .gate_b    (b2),
      .vec_idx   (vec2),
      .busy      (busy2),
      .done      (done2),
      .pass      (pass2),
`ifdef GTC_FAIL_MASK_EN
      .fail_mask (mask2),
`endif
      .err_count (err2)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic pulse_start1();
      @(negedge clk) start1 = 1'b1;
      @(posedge clk) #1 start1 = 1'b0;
   endtask

   task automatic pulse_start2();
      @(negedge clk) start2 = 1'b1;
      @(posedge clk) #1 start2 = 1'b0;
   endtask

   // One NOR run; optional start re-pulse at loop step repulse_at (0 = none).
   task automatic run_nor(input string tag, input logic [2:0] exp_err, input logic exp_pass,
                          input logic [3:0] exp_mask, input int repulse_at);
      pulse_start1();
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         @(negedge clk);
         start1 = (n == repulse_at);
         if (n % 3 == 1) begin
            chk({tag, "_ab"}, {30'd0, a1, b1}, 32'((n - 1) / 3));
            chk({tag, "_busy"}, busy1, 1);
         end
         if (n == 11)
            chk({tag, "_done_early"}, done1, 0);
      end
      start1 = 1'b0;
      chk({tag, "_done"}, done1, 1);
      chk({tag, "_busy_end"}, busy1, 0);
      chk({tag, "_err"}, err1, exp_err);
      chk({tag, "_pass"}, pass1, exp_pass);
      chk({tag, "_vec_hold"}, vec1, 3);
`ifdef GTC_FAIL_MASK_EN
      chk({tag, "_mask"}, mask1, exp_mask);
`else
      if (exp_mask === 4'hx) $display("unreachable");
`endif
   endtask

   task automatic run_nand(input string tag);
      pulse_start2();
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n % 2 == 1)
            chk({tag, "_ab"}, {30'd0, a2, b2}, 32'((n - 1) / 2));
         if (n == 1)
            chk({tag, "_busy"}, busy2, 1);
         if (n == 7)
            chk({tag, "_done_early"}, done2, 0);
      end
      chk({tag, "_done"}, done2, 1);
      chk({tag, "_err"}, err2, 0);
      chk({tag, "_pass"}, pass2, 1);
   endtask

   initial begin
      rst    = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      ymode  = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_vec", vec1, 0);
      chk("rst_ab", {a1, b1}, 0);
      chk("rst_flags", {busy1, done1, pass1}, 0);
      chk("rst_err", err1, 0);
      chk("rst_flags2", {busy2, done2, pass2}, 0);
      rst = 1'b0;

      run_nor("nor", 3'd0, 1'b1, 4'b0000, 0);
      ymode = 2'd1;
      run_nor("tie0", 3'd1, 1'b0, 4'b0001, 0);
      ymode = 2'd2;
      run_nor("tie1", 3'd3, 1'b0, 4'b1110, 0);
      ymode = 2'd0;
      run_nor("restart_ign", 3'd0, 1'b1, 4'b0000, 5);

      // abort mid-run at vector 2 with an error already counted
      ymode = 2'd1;
      pulse_start1();
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_vec", vec1, 2);
      chk("pre_rst_err", err1, 1);
      rst = 1'b1;
      #1;
      chk("arst_vec", vec1, 0);
      chk("arst_ab", {a1, b1}, 0);
      chk("arst_flags", {busy1, done1, pass1}, 0);
      chk("arst_err", err1, 0);
`ifdef GTC_FAIL_MASK_EN
      chk("arst_mask", mask1, 0);
`endif
      @(negedge clk) rst = 1'b0;
      ymode = 2'd0;
      run_nor("after_rst", 3'd0, 1'b1, 4'b0000, 0);

      run_nand("nand1");
      run_nand("nand2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
